// File: rtl/raw_fence_alloc.sv
`default_nettype none
// ============================================================================
// Module   : raw_fence_alloc
// Brief    : Raw-hits buffer write allocator feeding the fence queue.
//            Optional dropped-event counter built when RAW_DROP_CNT_EN is defined.
// Revision : 1.0
// ============================================================================
module raw_fence_alloc #(
  parameter int ADRB  = 11,
  parameter int MXADR = 2048,
  parameter int WDATA = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             evt_req,
  input  logic [ADRB:0]    evt_nwords,
  input  logic [31:0]      evt_tag,
  output logic             evt_rdy,
  input  logic             hit_vld,
  input  logic [WDATA-1:0] hit_data,
  output logic             buf_wr_en,
  output logic [ADRB-1:0]  buf_wr_adr,
  output logic [WDATA-1:0] buf_wr_data,
  output logic             fq_push,
  output logic [ADRB+31:0] fq_wr_data,
  input  logic             fq_full,
  input  logic             fq_empty,
  input  logic [ADRB+31:0] fq_rd_data,
  output logic             evt_done,
  output logic             evt_drop,
  output logic [ADRB:0]    free_words,
  output logic [15:0]      drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WRITE = 3'd2,
    S_FENCE = 3'd3,
    S_DROP  = 3'd4
  } state_t;

  localparam logic [ADRB:0] C_MXADR = (ADRB+1)'(MXADR);

  state_t          r_state;
  logic [ADRB-1:0] r_wr_adr;
  logic [ADRB-1:0] r_start_adr;
  logic [ADRB:0]   r_wcnt;
  logic [ADRB:0]   r_nwords;
  logic [31:0]     r_tag;

  logic [ADRB-1:0] w_used;
  logic [ADRB:0]   w_free;
  logic [ADRB:0]   w_wcnt_nxt;
  logic            w_accept;
  logic            w_unused_head_tag;

  // Equal pointers with a non-empty queue means the buffer is completely full.
  assign w_used     = r_wr_adr - fq_rd_data[ADRB-1:0];
  assign w_free     = fq_empty          ? C_MXADR :
                      (w_used == '0)    ? '0      :
                      C_MXADR - {1'b0, w_used};
  assign w_wcnt_nxt = r_wcnt + 1'b1;
  assign w_accept   = (r_nwords != '0) && (r_nwords <= free_words) && !fq_full;

  assign w_unused_head_tag = ^fq_rd_data[ADRB+31:ADRB];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      free_words <= C_MXADR;
    end else begin
      free_words <= w_free;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wr_adr    <= '0;
      r_start_adr <= '0;
      r_wcnt      <= '0;
      r_nwords    <= '0;
      r_tag       <= '0;
      evt_rdy     <= 1'b1;
      buf_wr_en   <= 1'b0;
      buf_wr_adr  <= '0;
      buf_wr_data <= '0;
      fq_push     <= 1'b0;
      fq_wr_data  <= '0;
      evt_done    <= 1'b0;
      evt_drop    <= 1'b0;
    end else begin
      buf_wr_en <= 1'b0;
      fq_push   <= 1'b0;
      evt_done  <= 1'b0;
      evt_drop  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (evt_req) begin
            r_nwords    <= evt_nwords;
            r_tag       <= evt_tag;
            r_start_adr <= r_wr_adr;
            r_wcnt      <= '0;
            evt_rdy     <= 1'b0;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_accept) begin
            r_state <= S_WRITE;
          end else begin
            evt_drop <= 1'b1;
            r_state  <= S_DROP;
          end
        end
        S_WRITE: begin
          if (hit_vld) begin
            buf_wr_en   <= 1'b1;
            buf_wr_adr  <= r_wr_adr;
            buf_wr_data <= hit_data;
            r_wr_adr    <= r_wr_adr + 1'b1;
            r_wcnt      <= w_wcnt_nxt;
            // Fence leaves together with the last word of the event.
            if (w_wcnt_nxt == r_nwords) begin
              fq_push    <= 1'b1;
              fq_wr_data <= {r_tag, r_start_adr};
              evt_done   <= 1'b1;
              r_state    <= S_FENCE;
            end
          end
        end
        S_FENCE, S_DROP: begin
          evt_rdy <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          evt_rdy <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RAW_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if ((r_state == S_CHECK) && !w_accept && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_raw_fence_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_raw_fence_alloc
// Brief    : Self-checking bench for raw_fence_alloc (ADRB=4, MXADR=16) with an
//            occupancy-based reference model and a bench-owned fence queue.
// Revision : 1.0
// ============================================================================
module tb_raw_fence_alloc;

  logic        clock = 1'b0;
  logic        reset;
  logic        evt_req;
  logic [4:0]  evt_nwords;
  logic [31:0] evt_tag;
  logic        evt_rdy;
  logic        hit_vld;
  logic [15:0] hit_data;
  logic        buf_wr_en;
  logic [3:0]  buf_wr_adr;
  logic [15:0] buf_wr_data;
  logic        fq_push;
  logic [35:0] fq_wr_data;
  logic        fq_full;
  logic        fq_empty = 1'b1;
  logic [35:0] fq_rd_data = '0;
  logic        evt_done;
  logic        evt_drop;
  logic [4:0]  free_words;
  logic [15:0] drop_cnt;

  raw_fence_alloc #(.ADRB(4), .MXADR(16), .WDATA(16)) dut (
    .clock(clock), .reset(reset),
    .evt_req(evt_req), .evt_nwords(evt_nwords), .evt_tag(evt_tag), .evt_rdy(evt_rdy),
    .hit_vld(hit_vld), .hit_data(hit_data),
    .buf_wr_en(buf_wr_en), .buf_wr_adr(buf_wr_adr), .buf_wr_data(buf_wr_data),
    .fq_push(fq_push), .fq_wr_data(fq_wr_data), .fq_full(fq_full),
    .fq_empty(fq_empty), .fq_rd_data(fq_rd_data),
    .evt_done(evt_done), .evt_drop(evt_drop),
    .free_words(free_words), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: write pointer, sizes and contents of queued fences, drops.
  int          m_wp = 0;
  int          m_fn[$];
  logic [35:0] m_fd[$];
  int          m_drops = 0;
  int          exp_adr[$];
  logic [15:0] exp_dat[$];
  int          fixed_gaps[$];

  // Observations collected on the falling edge.
  logic [3:0]  wr_adr_log[$];
  logic [15:0] wr_dat_log[$];
  logic [35:0] push_log[$];
  logic [35:0] fence_q[$];
  int n_done = 0, n_drop = 0, push_lone = 0, last_push_widx = 0;
  int pops_req = 0, pops_done = 0;

  always @(negedge clock) begin
    if (!reset) begin
      fence_q.delete();
    end else begin
      if (buf_wr_en) begin
        wr_adr_log.push_back(buf_wr_adr);
        wr_dat_log.push_back(buf_wr_data);
      end
      if (fq_push) begin
        push_log.push_back(fq_wr_data);
        fence_q.push_back(fq_wr_data);
        last_push_widx = wr_adr_log.size();
        if (!buf_wr_en) push_lone++;
      end
      if (evt_done) n_done++;
      if (evt_drop) n_drop++;
      if (pops_done < pops_req && fence_q.size() > 0) begin
        void'(fence_q.pop_front());
        pops_done++;
      end
    end
    fq_empty   = (fence_q.size() == 0);
    fq_rd_data = fq_empty ? 36'h0 : fence_q[0];
  end

  function automatic int model_free();
    int occ;
    occ = 0;
    if (m_fn.size() == 0) return 16;
    foreach (m_fn[i]) occ += m_fn[i];
    return 16 - occ;
  endfunction

  function automatic logic [15:0] exp_drop_cnt();
`ifdef RAW_DROP_CNT_EN
    return (m_drops > 65535) ? 16'hFFFF : 16'(m_drops);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_one();
    if (m_fn.size() > 0) begin
      void'(m_fn.pop_front());
      void'(m_fd.pop_front());
      pops_req++;
    end
    repeat (3) step();
  endtask

  // Drives one event request plus n hits (and one stray hit afterwards),
  // updates the model and returns log positions for the caller's checks.
  task automatic do_event(input int n, input logic [31:0] tag, input int max_gap,
                          output bit acc, output int wb, output int pb,
                          output int db, output int xb);
    int cyc, g;
    acc = (n > 0) && (n <= model_free()) && !fq_full;
    wb = wr_adr_log.size(); pb = push_log.size(); db = n_done; xb = n_drop;
    exp_adr.delete(); exp_dat.delete();
    cyc = 0;
    while (!evt_rdy && cyc < 40) begin step(); cyc++; end
    total++;
    if (evt_rdy !== 1'b1) begin bad++; $display("FAIL evt_rdy_wait got=%b want=1", evt_rdy); end
    evt_nwords = 5'(n); evt_tag = tag; evt_req = 1'b1;
    step();
    evt_req = 1'b0;
    step();
    for (int i = 0; i < n; i++) begin
      g = (fixed_gaps.size() > i) ? fixed_gaps[i] : int'($urandom_range(max_gap, 0));
      repeat (g) step();
      hit_vld = 1'b1; hit_data = 16'($urandom);
      if (acc) begin exp_adr.push_back((m_wp + i) % 16); exp_dat.push_back(hit_data); end
      step();
      hit_vld = 1'b0;
    end
    hit_vld = 1'b1; hit_data = 16'($urandom);
    step();
    hit_vld = 1'b0;
    repeat (3) step();
    if (acc) begin
      m_fn.push_back(n);
      m_fd.push_back({tag, 4'(m_wp)});
      m_wp = (m_wp + n) % 16;
    end else begin
      m_drops++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; evt_req = 1'b0; evt_nwords = '0; evt_tag = '0;
    hit_vld = 1'b0; hit_data = '0; fq_full = 1'b0;
    repeat (3) step();
    total++; if (buf_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", buf_wr_en); end
    total++; if (fq_push !== 1'b0) begin bad++; $display("FAIL reset_fq_push got=%b want=0", fq_push); end
    total++; if ({evt_done, evt_drop} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {evt_done, evt_drop}); end
    total++; if (buf_wr_adr !== 4'd0 || buf_wr_data !== 16'd0) begin bad++; $display("FAIL reset_wr_bus got=%h/%h want=0/0", buf_wr_adr, buf_wr_data); end
    total++; if (fq_wr_data !== 36'd0) begin bad++; $display("FAIL reset_fq_data got=%h want=0", fq_wr_data); end
    total++; if (free_words !== 5'd16) begin bad++; $display("FAIL reset_free got=%0d want=16", free_words); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
    reset = 1'b1;
    step();
    total++; if (evt_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", evt_rdy); end
  endtask

  task automatic test_basic();
    bit acc; int wb, pb, db, xb;
    do_event(5, 32'hA1, 0, acc, wb, pb, db, xb);
    total++; if (n_done - db !== 1 || n_drop - xb !== 0) begin bad++; $display("FAIL basic_done got=%0d/%0d want=1/0", n_done - db, n_drop - xb); end
    total++; if (wr_adr_log.size() - wb !== 5) begin bad++; $display("FAIL basic_nwr got=%0d want=5", wr_adr_log.size() - wb); end
    for (int i = 0; i < 5 && wb + i < wr_adr_log.size(); i++) begin
      total++; if (wr_adr_log[wb+i] !== 4'(i) || wr_dat_log[wb+i] !== exp_dat[i]) begin
        bad++; $display("FAIL basic_wr%0d got=%0d/%h want=%0d/%h", i, wr_adr_log[wb+i], wr_dat_log[wb+i], i, exp_dat[i]); end
    end
    total++; if (push_log.size() - pb !== 1) begin bad++; $display("FAIL basic_npush got=%0d want=1", push_log.size() - pb); end
    else begin
      total++; if (push_log[pb] !== {32'hA1, 4'd0}) begin bad++; $display("FAIL basic_fence got=%h want=%h", push_log[pb], {32'hA1, 4'd0}); end
    end
    total++; if (free_words !== 5'd11) begin bad++; $display("FAIL basic_free got=%0d want=11", free_words); end
  endtask

  task automatic test_space_wrap();
    bit acc; int wb, pb, db, xb;
    do_event(12, 32'hB1, 1, acc, wb, pb, db, xb);
    total++; if (n_drop - xb !== 1 || n_done - db !== 0) begin bad++; $display("FAIL big_drop got=%0d/%0d want=1/0", n_drop - xb, n_done - db); end
    total++; if (wr_adr_log.size() != wb || push_log.size() != pb) begin bad++; $display("FAIL big_nowrite got=%0d/%0d want=0/0", wr_adr_log.size() - wb, push_log.size() - pb); end
    total++; if (drop_cnt !== exp_drop_cnt()) begin bad++; $display("FAIL big_drop_cnt got=%0d want=%0d", drop_cnt, exp_drop_cnt()); end
    do_event(11, 32'hB2, 1, acc, wb, pb, db, xb);
    total++; if (n_done - db !== 1) begin bad++; $display("FAIL fit_done got=%0d want=1", n_done - db); end
    total++; if (wr_adr_log.size() - wb !== 11) begin bad++; $display("FAIL fit_nwr got=%0d want=11", wr_adr_log.size() - wb); end
    for (int i = 0; i < 11 && wb + i < wr_adr_log.size(); i++) begin
      total++; if (wr_adr_log[wb+i] !== 4'((5 + i) % 16)) begin bad++; $display("FAIL fit_adr%0d got=%0d want=%0d", i, wr_adr_log[wb+i], (5 + i) % 16); end
    end
    total++; if (push_log.size() - pb !== 1) begin bad++; $display("FAIL fit_npush got=%0d want=1", push_log.size() - pb); end
    else begin
      total++; if (push_log[pb] !== {32'hB2, 4'd5}) begin bad++; $display("FAIL fit_fence got=%h want=%h", push_log[pb], {32'hB2, 4'd5}); end
    end
    total++; if (free_words !== 5'd0) begin bad++; $display("FAIL fit_free got=%0d want=0", free_words); end
    pop_one();
    total++; if (free_words !== 5'd5) begin bad++; $display("FAIL pop1_free got=%0d want=5", free_words); end
    pop_one();
    total++; if (free_words !== 5'd16) begin bad++; $display("FAIL pop2_free got=%0d want=16", free_words); end
  endtask

  task automatic test_fq_full();
    bit acc; int wb, pb, db, xb;
    fq_full = 1'b1;
    do_event(1, 32'hF0, 0, acc, wb, pb, db, xb);
    fq_full = 1'b0;
    total++; if (n_drop - xb !== 1) begin bad++; $display("FAIL full_drop got=%0d want=1", n_drop - xb); end
    total++; if (push_log.size() != pb || wr_adr_log.size() != wb) begin bad++; $display("FAIL full_nopush got=%0d/%0d want=0/0", push_log.size() - pb, wr_adr_log.size() - wb); end
  endtask

  task automatic test_bad_nwords();
    bit acc; int wb, pb, db, xb, wb0, xb0;
    wb0 = wr_adr_log.size(); xb0 = n_drop;
    do_event(0, 32'hE0, 0, acc, wb, pb, db, xb);
    do_event(17, 32'hE1, 0, acc, wb, pb, db, xb);
    total++; if (n_drop - xb0 !== 2) begin bad++; $display("FAIL badn_drops got=%0d want=2", n_drop - xb0); end
    total++; if (wr_adr_log.size() != wb0) begin bad++; $display("FAIL badn_nowrite got=%0d want=0", wr_adr_log.size() - wb0); end
    total++; if (drop_cnt !== exp_drop_cnt()) begin bad++; $display("FAIL badn_drop_cnt got=%0d want=%0d", drop_cnt, exp_drop_cnt()); end
  endtask

  task automatic test_gaps();
    bit acc; int wb, pb, db, xb, lone0;
    lone0 = push_lone;
    fixed_gaps = '{0, 1, 2};
    do_event(3, 32'hC3, 0, acc, wb, pb, db, xb);
    fixed_gaps.delete();
    total++; if (wr_adr_log.size() - wb !== 3) begin bad++; $display("FAIL gaps_nwr got=%0d want=3", wr_adr_log.size() - wb); end
    total++; if (push_log.size() - pb !== 1 || last_push_widx !== wb + 3) begin
      bad++; $display("FAIL gaps_push got=%0d@%0d want=1@%0d", push_log.size() - pb, last_push_widx, wb + 3); end
    total++; if (push_lone !== lone0) begin bad++; $display("FAIL gaps_push_align got=%0d want=%0d", push_lone, lone0); end
    pop_one();
  endtask

  task automatic test_reset_mid();
    bit acc; int wb, pb, db, xb;
    pb = push_log.size(); db = n_done;
    evt_nwords = 5'd4; evt_tag = 32'hD0; evt_req = 1'b1;
    step();
    evt_req = 1'b0;
    step();
    hit_vld = 1'b1; hit_data = 16'h1111;
    repeat (2) step();
    hit_vld = 1'b0;
    step();
    reset = 1'b0;
    #1;
    total++; if (evt_rdy !== 1'b1 || buf_wr_en !== 1'b0) begin bad++; $display("FAIL rstmid_async got=%b%b want=10", evt_rdy, buf_wr_en); end
    repeat (2) step();
    reset = 1'b1;
    step();
    m_wp = 0; m_fn.delete(); m_fd.delete(); m_drops = 0;
    total++; if (push_log.size() != pb || n_done != db) begin bad++; $display("FAIL rstmid_nofence got=%0d want=0", push_log.size() - pb); end
    total++; if (evt_rdy !== 1'b1) begin bad++; $display("FAIL rstmid_rdy got=%b want=1", evt_rdy); end
    do_event(2, 32'hD4, 0, acc, wb, pb, db, xb);
    total++; if (wr_adr_log.size() - wb !== 2 || wr_adr_log[wb] !== 4'd0) begin
      bad++; $display("FAIL rstmid_adr got=%0d want=0", (wr_adr_log.size() > wb) ? int'(wr_adr_log[wb]) : -1); end
    total++; if (push_log.size() - pb !== 1 || push_log[pb] !== {32'hD4, 4'd0}) begin bad++; $display("FAIL rstmid_fence got=%0d pushes want=1 {D4,0}", push_log.size() - pb); end
    pop_one();
  endtask

  task automatic test_random();
    bit acc; int wb, pb, db, xb, n, nexp;
    for (int it = 0; it < 40; it++) begin
      n = ($urandom_range(3, 0) == 0) ? int'($urandom_range(17, 0)) : int'($urandom_range(6, 1));
      fq_full = ($urandom_range(7, 0) == 0);
      do_event(n, $urandom, 2, acc, wb, pb, db, xb);
      fq_full = 1'b0;
      nexp = acc ? n : 0;
      total++; if (n_done - db !== int'(acc) || n_drop - xb !== int'(!acc)) begin
        bad++; $display("FAIL rnd%0d_decision got=%0d/%0d want=%0d/%0d", it, n_done - db, n_drop - xb, acc, !acc); end
      total++; if (wr_adr_log.size() - wb !== nexp) begin bad++; $display("FAIL rnd%0d_nwr got=%0d want=%0d", it, wr_adr_log.size() - wb, nexp); end
      else begin
        for (int i = 0; i < nexp; i++) begin
          total++; if (wr_adr_log[wb+i] !== 4'(exp_adr[i]) || wr_dat_log[wb+i] !== exp_dat[i]) begin
            bad++; $display("FAIL rnd%0d_wr%0d got=%0d/%h want=%0d/%h", it, i, wr_adr_log[wb+i], wr_dat_log[wb+i], exp_adr[i], exp_dat[i]); end
        end
      end
      total++; if (push_log.size() - pb !== int'(acc)) begin bad++; $display("FAIL rnd%0d_npush got=%0d want=%0d", it, push_log.size() - pb, acc); end
      else if (acc) begin
        total++; if (push_log[pb] !== m_fd[m_fd.size()-1]) begin bad++; $display("FAIL rnd%0d_fence got=%h want=%h", it, push_log[pb], m_fd[m_fd.size()-1]); end
      end
      total++; if (free_words !== 5'(model_free())) begin bad++; $display("FAIL rnd%0d_free got=%0d want=%0d", it, free_words, model_free()); end
      total++; if (drop_cnt !== exp_drop_cnt()) begin bad++; $display("FAIL rnd%0d_drop_cnt got=%0d want=%0d", it, drop_cnt, exp_drop_cnt()); end
      if ($urandom_range(2, 0) == 0 || model_free() < 5) begin
        repeat ($urandom_range(2, 1)) pop_one();
        total++; if (free_words !== 5'(model_free())) begin bad++; $display("FAIL rnd%0d_popfree got=%0d want=%0d", it, free_words, model_free()); end
      end
    end
    total++; if (push_lone !== 0) begin bad++; $display("FAIL push_without_write got=%0d want=0", push_lone); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_space_wrap();
    test_fq_full();
    test_bad_nwords();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
